branch_redirect_unit: RTL and testbench

- Consumer end of the EX-stage branch decision. Takes the resolved branch outcome (switch_branch / target) and drives the PC redirect mux plus the IF/ID and ID/EX flush strobes.
- Holds a pending redirect while fetch cannot accept a new PC.
- Stretches IF/ID flush over a configurable number of cycles for deeper fetch.
- Sits between the branch control logic and the PC / pipeline-register update logic.

---
 rtl/branch_redirect_unit.sv | 124 ++++++++++++
 tb/tb_branch_redirect_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - EX-stage branch redirect: PC mux select, IF/ID + ID/EX flush strobes.
// Optional BRANCH_STATS_EN adds saturating taken-branch and flush-cycle counters.
module branch_redirect_unit #(
   parameter int XLEN         = 64,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            branch_valid_in,
   input  logic            switch_branch_in,
   input  logic [XLEN-1:0] target_in,
   input  logic            fetch_ready,
   input  logic            stall_in,
   output logic            pc_sel_out,
   output logic [XLEN-1:0] pc_target_out,
   output logic            flush_ifid_out,
   output logic            flush_idex_out,
   output logic            redirect_busy_out
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     taken_count_out,
   output logic [31:0]     flush_cycle_count_out
`endif
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;

   localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("branch_redirect_unit: FLUSH_CYCLES=%0d outside 1..15", FLUSH_CYCLES);
   end

   logic [1:0]      state;
   logic [XLEN-1:0] tgt_q;
   logic [3:0]      cnt;
   logic            take;

   // Branches arriving while busy are wrong-path and never reach this term.
   assign take = (state == IDLE) && branch_valid_in && switch_branch_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         tgt_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  tgt_q <= target_in;
                  state <= REDIRECT;
               end
            end
            REDIRECT: begin
               if (fetch_ready) begin
                  if (FLUSH_CYCLES == 1) begin
                     state <= IDLE;
                  end else begin
                     state <= FLUSH;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            FLUSH: begin
               if (!stall_in) begin
                  if (cnt == 4'd1) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      pc_sel_out        = 1'b0;
      flush_ifid_out    = 1'b0;
      flush_idex_out    = 1'b0;
      redirect_busy_out = 1'b0;
      pc_target_out     = tgt_q;
      case (state)
         REDIRECT: begin
            pc_sel_out        = 1'b1;
            flush_ifid_out    = 1'b1;
            flush_idex_out    = 1'b1;
            redirect_busy_out = 1'b1;
         end
         FLUSH: begin
            flush_ifid_out    = 1'b1;
            redirect_busy_out = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] taken_q;
   logic [31:0] flush_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         taken_q <= '0;
         flush_q <= '0;
      end else begin
         if (take && taken_q != 32'hFFFF_FFFF) begin
            taken_q <= taken_q + 32'd1;
         end
         if (flush_ifid_out && flush_q != 32'hFFFF_FFFF) begin
            flush_q <= flush_q + 32'd1;
         end
      end
   end

   assign taken_count_out       = taken_q;
   assign flush_cycle_count_out = flush_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - bench for branch_redirect_unit with FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances.
module tb_branch_redirect_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        bv, sw, fr, stall;
   logic [63:0] tgt;

   logic        pc_sel [2];
   logic [63:0] pc_tgt [2];
   logic        ifid [2];
   logic        idex [2];
   logic        busy [2];
   logic [67:0] obs [2];
`ifdef BRANCH_STATS_EN
   logic [31:0] taken_cnt [2];
   logic [31:0] flush_cnt [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending redirect flag plus remaining flush-only cycles.
   bit          m_redir [2];
   int          m_left  [2];
   logic [63:0] m_tgt   [2];
   int          m_ncyc  [2];
   longint      m_taken [2];
   longint      m_flc   [2];

   always #5 clk = ~clk;

   branch_redirect_unit #(.XLEN(64), .FLUSH_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .branch_valid_in(bv), .switch_branch_in(sw),
      .target_in(tgt), .fetch_ready(fr), .stall_in(stall),
      .pc_sel_out(pc_sel[0]), .pc_target_out(pc_tgt[0]), .flush_ifid_out(ifid[0]),
      .flush_idex_out(idex[0]), .redirect_busy_out(busy[0])
`ifdef BRANCH_STATS_EN
      , .taken_count_out(taken_cnt[0]), .flush_cycle_count_out(flush_cnt[0])
`endif
   );

   branch_redirect_unit #(.XLEN(64), .FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .branch_valid_in(bv), .switch_branch_in(sw),
      .target_in(tgt), .fetch_ready(fr), .stall_in(stall),
      .pc_sel_out(pc_sel[1]), .pc_target_out(pc_tgt[1]), .flush_ifid_out(ifid[1]),
      .flush_idex_out(idex[1]), .redirect_busy_out(busy[1])
`ifdef BRANCH_STATS_EN
      , .taken_count_out(taken_cnt[1]), .flush_cycle_count_out(flush_cnt[1])
`endif
   );

   assign obs[0] = {pc_sel[0], ifid[0], idex[0], busy[0], pc_tgt[0]};
   assign obs[1] = {pc_sel[1], ifid[1], idex[1], busy[1], pc_tgt[1]};

   function automatic logic [67:0] exp_vec(int k);
      logic fl;
      fl = m_redir[k] || (m_left[k] > 0);
      return {m_redir[k], fl, m_redir[k], fl, m_tgt[k]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_redir[k] = 0;
         m_left[k]  = 0;
         m_tgt[k]   = '0;
         m_taken[k] = 0;
         m_flc[k]   = 0;
      end
   endtask

   // Advance model with current inputs, then clock the DUTs.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         if (m_redir[k] || m_left[k] > 0) m_flc[k]++;
         if (m_redir[k]) begin
            if (fr) begin
               m_redir[k] = 0;
               m_left[k]  = m_ncyc[k] - 1;
            end
         end else if (m_left[k] > 0) begin
            if (!stall) m_left[k]--;
         end else if (bv && sw) begin
            m_tgt[k]   = tgt;
            m_redir[k] = 1;
            m_taken[k]++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; bv = 0; sw = 0; fr = 0; stall = 0; tgt = '0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (obs[k] !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d got %h want 0", k, obs[k]);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (obs[0] !== exp_vec(0) || obs[1] !== exp_vec(1)) begin
         n_fail++;
         $display("FAIL reset_release got %h/%h want %h/%h", obs[0], obs[1], exp_vec(0), exp_vec(1));
      end
   endtask

   task automatic test_idle_drain();
      bv = 0; sw = 0; fr = 1; stall = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (obs[0] !== exp_vec(0) || obs[1] !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL drain got %h/%h want %h/%h", obs[0], obs[1], exp_vec(0), exp_vec(1));
         end
      end
   endtask

   task automatic test_taken_fc1();
      bv = 1; sw = 1; tgt = 64'h100; fr = 1; stall = 0;
      tick();
      bv = 0; sw = 0;
      n_checks++;
      if (obs[0] !== {4'b1111, 64'h100}) begin
         n_fail++;
         $display("FAIL taken_redirect got %h want %h", obs[0], {4'b1111, 64'h100});
      end
      tick();
      n_checks++;
      if (obs[0] !== {4'b0000, 64'h100} || obs[0] !== exp_vec(0)) begin
         n_fail++;
         $display("FAIL taken_back_idle got %h want %h", obs[0], {4'b0000, 64'h100});
      end
   endtask

   task automatic test_not_taken();
      bv = 1; sw = 0; tgt = 64'h200; fr = 1;
      tick();
      n_checks++;
      if (obs[0] !== {4'b0000, 64'h100} || obs[0] !== exp_vec(0)) begin
         n_fail++;
         $display("FAIL not_taken got %h want %h", obs[0], {4'b0000, 64'h100});
      end
      bv = 0; sw = 1; tgt = 64'h300;
      tick();
      sw = 0;
      n_checks++;
      if (obs[0] !== {4'b0000, 64'h100}) begin
         n_fail++;
         $display("FAIL switch_without_valid got %h want %h", obs[0], {4'b0000, 64'h100});
      end
   endtask

   task automatic test_hold();
      int held;
      held = 0;
      bv = 1; sw = 1; tgt = 64'h100; fr = 0;
      tick();
      for (int i = 0; i < 6; i++) begin
         if (pc_sel[0]) held++;
         n_checks++;
         if (obs[0] !== exp_vec(0) || pc_tgt[0] !== 64'h100) begin
            n_fail++;
            $display("FAIL hold_cycle%0d got %h want %h", i, obs[0], exp_vec(0));
         end
         bv  = (i == 1);
         sw  = (i == 1);
         tgt = (i == 1) ? 64'h200 : 64'h100;
         fr  = (i >= 3);
         tick();
      end
      bv = 0; sw = 0;
      n_checks++;
      if (held !== 4) begin
         n_fail++;
         $display("FAIL hold_length got %0d want 4", held);
      end
   endtask

   task automatic test_stall_fc3();
      int n_ifid, n_idex;
      n_ifid = 0; n_idex = 0;
      bv = 1; sw = 1; tgt = 64'h40; fr = 1; stall = 0;
      tick();
      bv = 0; sw = 0;
      for (int i = 0; i < 8; i++) begin
         if (ifid[1]) n_ifid++;
         if (idex[1]) n_idex++;
         n_checks++;
         if (obs[1] !== exp_vec(1)) begin
            n_fail++;
            $display("FAIL stall_fc3_cycle%0d got %h want %h", i, obs[1], exp_vec(1));
         end
         stall = (i == 1);
         tick();
      end
      stall = 0;
      n_checks++;
      if (n_ifid !== 4 || n_idex !== 1) begin
         n_fail++;
         $display("FAIL stall_fc3_counts got ifid=%0d idex=%0d want ifid=4 idex=1", n_ifid, n_idex);
      end
   endtask

   task automatic test_async_reset();
      bv = 1; sw = 1; tgt = 64'hDEAD_BEEF_0000_1234; fr = 0;
      tick();
      bv = 0; sw = 0;
      n_checks++;
      if (obs[0] !== {4'b1111, 64'hDEAD_BEEF_0000_1234}) begin
         n_fail++;
         $display("FAIL async_pre got %h want %h", obs[0], {4'b1111, 64'hDEAD_BEEF_0000_1234});
      end
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (obs[k] !== 68'h0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d got %h want 0", k, obs[k]);
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      fr = 1;
      model_reset();
      tick();
      n_checks++;
      if (obs[0] !== 68'h0 || obs[1] !== 68'h0) begin
         n_fail++;
         $display("FAIL after_reset_idle got %h/%h want 0", obs[0], obs[1]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bv    = ($urandom_range(0, 1) == 1);
         sw    = ($urandom_range(0, 1) == 1);
         fr    = ($urandom_range(0, 9) < 7);
         stall = ($urandom_range(0, 9) < 3);
         tgt   = {$urandom, $urandom};
         tick();
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL random_cycle%0d dut%0d got %h want %h", i, k, obs[k], exp_vec(k));
            end
         end
      end
`ifdef BRANCH_STATS_EN
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (taken_cnt[k] !== 32'(m_taken[k]) || flush_cnt[k] !== 32'(m_flc[k])) begin
            n_fail++;
            $display("FAIL stats dut%0d got %0d/%0d want %0d/%0d", k, taken_cnt[k], flush_cnt[k], m_taken[k], m_flc[k]);
         end
      end
`endif
   endtask

   initial begin
      m_ncyc[0] = 1;
      m_ncyc[1] = 3;
      test_reset();
      test_taken_fc1();
      test_idle_drain();
      test_not_taken();
      test_hold();
      test_idle_drain();
      test_stall_fc3();
      test_idle_drain();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
